// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared grid width, sequencer state encoding and still-life helper
package life_pkg;

    localparam int GRID_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_PAUSE = 2'b11
    } life_state_t;

    // A grid that maps onto itself, or an empty grid, can never change again
    function automatic logic is_still(input logic [GRID_W-1:0] grid,
                                      input logic [GRID_W-1:0] grid_next);
        return (grid_next == grid) || (grid == '0);
    endfunction

endpackage

// File: rtl/life_sequencer_if.sv
// rtl/life_sequencer_if.sv - datapath handshake between sequencer (master) and grid datapath (slave)
interface life_sequencer_if;

    logic [life_pkg::GRID_W-1:0] grid;
    logic [life_pkg::GRID_W-1:0] grid_next;
    logic                        load;
    logic                        seed_sel;
    logic                        evolve;

    modport master (
        input  grid,
        input  grid_next,
        output load,
        output seed_sel,
        output evolve
    );

    modport slave (
        output grid,
        output grid_next,
        input  load,
        input  seed_sel,
        input  evolve
    );

endinterface

// File: rtl/life_tick_timer.sv
// rtl/life_tick_timer.sv - generation period counter; new period is latched on clear or wrap
module life_tick_timer #(
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                wrap
);

    logic [PERIOD_W-1:0] count_q, count_d;
    logic [PERIOD_W-1:0] last_q, last_d;
    logic [PERIOD_W-1:0] period_last;

    // period 0 behaves as period 1
    assign period_last = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign wrap        = enable && (count_q == last_q);

    always_comb begin
        count_d = count_q;
        last_d  = last_q;
        if (clear) begin
            count_d = '0;
            last_d  = period_last;
        end else if (wrap) begin
            count_d = '0;
            last_d  = period_last;
        end else if (enable) begin
            count_d = count_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            last_q  <= '0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - Game of Life run/pause/step sequencer; LIFE_STILL_DETECT_EN adds still-life/extinction stop
module life_sequencer
    import life_pkg::*;
#(
    parameter int PERIOD_W = 8,
    parameter int GEN_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                step,
    input  logic                lfsr_begin,
    input  logic [PERIOD_W-1:0] period,
    life_sequencer_if.master    dp,
    output logic [GEN_W-1:0]    gen_count,
    output logic [1:0]          curr_state,
    output logic                done
);

    logic [1:0]  rst_sync_q, rst_sync_d;
    logic        rst_n;

    life_state_t state_q, state_d;
    logic        seed_sel_q, seed_sel_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic        step_prev_q, step_prev_d;
    logic        step_rise;
    logic        evolve_req;
    logic        evolve;
    logic        load;
    logic        timer_clear;
    logic        timer_en;
    logic        wrap;

    // Assertion is immediate; release is delayed two edges so state cannot leave IDLE early
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign timer_en    = (state_q == ST_RUN) && !stop;
    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                         ((state_q == ST_PAUSE) && start && !stop);
    assign step_rise   = step && !step_prev_q;
    assign step_prev_d = step;

    life_tick_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .period (period),
        .wrap   (wrap)
    );

`ifdef LIFE_STILL_DETECT_EN
    logic done_q, done_d;
`endif

    always_comb begin
        state_d    = state_q;
        seed_sel_d = seed_sel_q;
        gen_d      = gen_q;
        evolve_req = 1'b0;
        load       = 1'b0;
`ifdef LIFE_STILL_DETECT_EN
        done_d     = done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!stop && start) begin
                    state_d    = ST_LOAD;
                    seed_sel_d = lfsr_begin;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                gen_d   = '0;
`ifdef LIFE_STILL_DETECT_EN
                done_d  = 1'b0;
`endif
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else begin
                    evolve_req = wrap;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    evolve_req = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        evolve = evolve_req;
`ifdef LIFE_STILL_DETECT_EN
        if (evolve_req && is_still(dp.grid, dp.grid_next)) begin
            evolve  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
`endif
        if (evolve && (gen_q != {GEN_W{1'b1}})) begin
            gen_d = gen_q + GEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            seed_sel_q  <= 1'b0;
            gen_q       <= '0;
            step_prev_q <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            seed_sel_q  <= seed_sel_d;
            gen_q       <= gen_d;
            step_prev_q <= step_prev_d;
`ifdef LIFE_STILL_DETECT_EN
            done_q      <= done_d;
`endif
        end
    end

    assign dp.load     = load;
    assign dp.seed_sel = seed_sel_q;
    assign dp.evolve   = evolve;
    assign gen_count   = gen_q;
    assign curr_state  = state_q;
`ifdef LIFE_STILL_DETECT_EN
    assign done        = done_q;
`else
    assign done        = 1'b0;
`endif

endmodule

// File: tb/tb_life_sequencer.sv
// tb/tb_life_sequencer.sv - directed self-checking bench for life_sequencer
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        step = 1'b0;
    logic        lfsr_begin = 1'b0;
    logic [7:0]  period = 8'd3;
    logic [15:0] gen_count;
    logic [3:0]  gen_count4;
    logic [1:0]  curr_state, curr_state4;
    logic        done, done4;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [63:0] BLOCK = 64'h0000_0018_1800_0000;

    life_sequencer_if dp();
    life_sequencer_if dp4();

    assign dp4.grid      = dp.grid;
    assign dp4.grid_next = dp.grid_next;

    always #5 clk = ~clk;

    life_sequencer #(.PERIOD_W(8), .GEN_W(16)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .lfsr_begin (lfsr_begin),
        .period     (period),
        .dp         (dp),
        .gen_count  (gen_count),
        .curr_state (curr_state),
        .done       (done)
    );

    life_sequencer #(.PERIOD_W(8), .GEN_W(4)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .lfsr_begin (lfsr_begin),
        .period     (period),
        .dp         (dp4),
        .gen_count  (gen_count4),
        .curr_state (curr_state4),
        .done       (done4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        dp.grid      = 64'h1;
        dp.grid_next = 64'h2;

        // reset state
        #2;
        check("rst_state",    curr_state,  0);
        check("rst_load",     dp.load,     0);
        check("rst_evolve",   dp.evolve,   0);
        check("rst_seed_sel", dp.seed_sel, 0);
        check("rst_gen",      gen_count,   0);
        check("rst_done",     done,        0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("post_rst_idle", curr_state, 0);

        // period 3 run from external seed
        @(negedge clk); start = 1'b1; lfsr_begin = 1'b0;
        #1 check("idle_no_load", dp.load, 0);
        @(negedge clk); start = 1'b0;
        #1;
        check("load_state",    curr_state,  1);
        check("load_pulse",    dp.load,     1);
        check("load_seed_sel", dp.seed_sel, 0);
        check("load_no_evolve", dp.evolve,  0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk); #1;
            check("p3_state",  curr_state, 2);
            check("p3_evolve", dp.evolve,  (i % 3 == 0));
            check("p3_gen",    gen_count,  (i - 1) / 3);
        end

        // period change lands at next wrap
        @(negedge clk); period = 8'd4;
        #1;
        check("p3_gen_final", gen_count, 3);
        check("chg_evolve0",  dp.evolve, 0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk); #1;
            check("chg_evolve", dp.evolve, (j == 2));
            check("chg_gen",    gen_count, (j <= 2) ? 3 : 4);
        end

        // stop in an evolve cycle suppresses it
        @(negedge clk); stop = 1'b1;
        #1;
        check("stop_evolve", dp.evolve,  0);
        check("stop_state",  curr_state, 2);
        @(negedge clk); stop = 1'b0;
        #1;
        check("pause_state",  curr_state, 3);
        check("pause_evolve", dp.evolve,  0);
        check("pause_gen",    gen_count,  4);
        @(negedge clk); step = 1'b1;
        #1 check("step_evolve", dp.evolve, 1);
        @(negedge clk);
        #1;
        check("step_held", dp.evolve, 0);
        check("step_gen",  gen_count, 5);
        @(negedge clk); step = 1'b0;
        #1;
        check("step_low",    dp.evolve,  0);
        check("step_paused", curr_state, 3);

        // start+stop+step together in PAUSE
        @(negedge clk); start = 1'b1; stop = 1'b1; step = 1'b1;
        #1 check("ss_evolve", dp.evolve, 0);
        @(negedge clk); start = 1'b0; stop = 1'b0; step = 1'b0;
        #1;
        check("ss_state",  curr_state, 0);
        check("ss_evolve2", dp.evolve, 0);

        // LFSR seed, then asynchronous reset mid-run
        @(negedge clk); start = 1'b1; lfsr_begin = 1'b1; period = 8'd2;
        @(negedge clk); start = 1'b0;
        #1;
        check("lfsr_load",     dp.load,     1);
        check("lfsr_seed_sel", dp.seed_sel, 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); #1;
            check("p2_evolve", dp.evolve, (i % 2 == 0));
            check("p2_gen",    gen_count, (i - 1) / 2);
        end
        #2 reset = 1'b0;
        #1;
        check("arst_state",    curr_state,  0);
        check("arst_gen",      gen_count,   0);
        check("arst_seed_sel", dp.seed_sel, 0);
        check("arst_load",     dp.load,     0);
        check("arst_evolve",   dp.evolve,   0);
        check("arst_done",     done,        0);
        @(negedge clk); reset = 1'b1; start = 1'b1; lfsr_begin = 1'b0;
        @(negedge clk);
        #1 check("sync_hold_idle", curr_state, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("sync_idle", curr_state, 0);

        // still-life grid
        dp.grid = BLOCK; dp.grid_next = BLOCK; period = 8'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 check("still_load", dp.load, 1);
        @(negedge clk); #1;
        check("still_state_run", curr_state, 2);
`ifdef LIFE_STILL_DETECT_EN
        check("still_evolve", dp.evolve, 0);
        @(negedge clk); #1;
        check("still_state", curr_state, 0);
        check("still_done",  done,       1);
        check("still_gen",   gen_count,  0);
`else
        check("still_evolve", dp.evolve, 1);
        @(negedge clk); #1;
        check("still_state", curr_state, 2);
        check("still_done",  done,       0);
        check("still_gen",   gen_count,  1);
`endif
        @(negedge clk); stop = 1'b1;
        @(negedge clk);
        @(negedge clk); stop = 1'b0;
        #1 check("still_idle", curr_state, 0);
        dp.grid = 64'h1; dp.grid_next = 64'h2;

        // GEN_W=4 saturation at period 1
        @(negedge clk); start = 1'b1; period = 8'd1;
        @(negedge clk); start = 1'b0;
        #1 check("sat_load", curr_state4, 1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); #1;
            check("sat_evolve",  dp4.evolve, 1);
            check("sat_gen4",    gen_count4, (i - 1 > 15) ? 15 : i - 1);
            check("sat_gen16",   gen_count,  i - 1);
        end
        @(negedge clk); #1;
        check("sat_gen4_final",  gen_count4, 15);
        check("sat_gen16_final", gen_count,  20);
        check("sat_done",        done4,      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
